// File: rtl/fft_stage_sched_if.sv
// Control/emit bundle between the SDF stage sequencer and its neighbours.
// master: input framing side (drives beats, observes controls and emits).
// slave:  the sequencer itself.
interface fft_stage_sched_if #(
  parameter int unsigned FRAME_CLKS = 32
);
  localparam int unsigned TW = $clog2(FRAME_CLKS / 2);

  logic          din_valid;
  logic          din_sof;
  logic          sr_shift_en;
  logic          sr_din_sel;
  logic          bf_en;
  logic          emit_valid;
  logic          emit_sel;
  logic [TW-1:0] emit_tw_idx;
  logic          emit_last;
  logic          err_sof;
  logic          busy;

  modport master (
    output din_valid, din_sof,
    input  sr_shift_en, sr_din_sel, bf_en,
    input  emit_valid, emit_sel, emit_tw_idx, emit_last, err_sof, busy
  );

  modport slave (
    input  din_valid, din_sof,
    output sr_shift_en, sr_din_sel, bf_en,
    output emit_valid, emit_sel, emit_tw_idx, emit_last, err_sof, busy
  );
endinterface

// File: rtl/fft_stage_sched.sv
// Sequencer for one radix-2 SDF FFT stage. Tracks beat position within a frame,
// drives the delay-line / butterfly controls combinationally and produces a
// registered emit stream aligned with the one-cycle butterfly register.
// First half of a frame fills the delay line (draining the previous frame's
// difference beats), second half computes butterflies and emits sums.
module fft_stage_sched #(
  parameter int unsigned FRAME_CLKS = 32
) (
  input logic               clk,
  input logic               rst,
  fft_stage_sched_if.slave  io
);
  localparam int unsigned HALF = FRAME_CLKS / 2;
  localparam int unsigned CW   = $clog2(FRAME_CLKS);
  localparam int unsigned TW   = $clog2(HALF);

  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          in_frame_q, in_frame_d;
  logic [TW:0]   drain_cnt_q, drain_cnt_d;

  logic          emit_valid_q, emit_valid_d;
  logic          emit_sel_q, emit_sel_d;
  logic [TW-1:0] emit_tw_q, emit_tw_d;
  logic          emit_last_q, emit_last_d;
  logic          err_sof_q, err_sof_d;

  logic          in_fire;
  logic          abort;
  logic          fill;
  logic          compute;
  logic          drain_tick;
  logic          emit_diff;
  logic [CW-1:0] beat;
  logic [TW:0]   tw_full;

  // Beat qualification and phase decode for the current cycle.
  always_comb begin
    in_fire    = io.din_valid && (io.din_sof || in_frame_q);
    abort      = in_fire && io.din_sof && in_frame_q;
    beat       = io.din_sof ? '0 : beat_cnt_q;
    fill       = in_fire && (beat < CW'(HALF));
    compute    = in_fire && !(beat < CW'(HALF));
    // Draining self-clocks only when no frame holds the shared delay line.
    drain_tick = !in_frame_q && !in_fire && (drain_cnt_q != '0);
    // An aborting sof discards pending differences, so it emits nothing.
    emit_diff  = ((fill && !abort) || drain_tick) && (drain_cnt_q != '0);
    tw_full    = (TW+1)'(HALF) - drain_cnt_q;
  end

  assign io.sr_shift_en = fill | compute | drain_tick;
  assign io.sr_din_sel  = compute;
  assign io.bf_en       = compute;
  assign io.busy        = in_frame_q || (drain_cnt_q != '0);

  assign io.emit_valid  = emit_valid_q;
  assign io.emit_sel    = emit_sel_q;
  assign io.emit_tw_idx = emit_tw_q;
  assign io.emit_last   = emit_last_q;
  assign io.err_sof     = err_sof_q;

  // Next-state for frame position, drain counter and emit registers.
  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    in_frame_d   = in_frame_q;
    drain_cnt_d  = drain_cnt_q;
    emit_valid_d = emit_diff | compute;
    emit_sel_d   = emit_diff;
    emit_tw_d    = emit_diff ? tw_full[TW-1:0] : '0;
    emit_last_d  = emit_diff && (drain_cnt_q == (TW+1)'(1));
    err_sof_d    = abort;

    if (abort) begin
      drain_cnt_d = '0;
    end else if (emit_diff) begin
      drain_cnt_d = drain_cnt_q - (TW+1)'(1);
    end

    if (in_fire) begin
      if (beat == CW'(FRAME_CLKS - 1)) begin
        // Frame complete: its HALF difference beats now wait in the delay line.
        in_frame_d  = 1'b0;
        beat_cnt_d  = '0;
        drain_cnt_d = (TW+1)'(HALF);
      end else begin
        in_frame_d  = 1'b1;
        beat_cnt_d  = beat + 1'b1;
      end
    end
  end

  // State and registered outputs; async reset discards any frame or drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q   <= '0;
      in_frame_q   <= 1'b0;
      drain_cnt_q  <= '0;
      emit_valid_q <= 1'b0;
      emit_sel_q   <= 1'b0;
      emit_tw_q    <= '0;
      emit_last_q  <= 1'b0;
      err_sof_q    <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      in_frame_q   <= in_frame_d;
      drain_cnt_q  <= drain_cnt_d;
      emit_valid_q <= emit_valid_d;
      emit_sel_q   <= emit_sel_d;
      emit_tw_q    <= emit_tw_d;
      emit_last_q  <= emit_last_d;
      err_sof_q    <= err_sof_d;
    end
  end

endmodule
